// File: rtl/fp_mult_seq_if.sv
// Handshake and data bundle for the sequential float multiplier.
// The requester side (operand producer and result consumer) uses the master
// modport. The multiplier itself uses the slave modport.
interface fp_mult_seq_if #(
    parameter int W = 12
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         ovf;
    logic         unf;
    logic         zero;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, z, ovf, unf, zero
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, z, ovf, unf, zero
    );
endinterface

// File: rtl/fp_mult_seq.sv
// Sequential sign/exponent/mantissa float multiplier with a hidden leading one.
// The mantissa product is built by a radix-2 shift-add loop over MW+1 cycles.
// It is rounded to nearest-even.
// Results saturate on overflow and flush to zero on underflow.
// An operand with a zero exponent field counts as zero.
module fp_mult_seq #(
    parameter int EW   = 4,
    parameter int MW   = 7,
    parameter int BIAS = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    fp_mult_seq_if.slave bus
);
    localparam int W  = 1 + EW + MW;
    localparam int PW = 2 * MW + 2;
    localparam int CW = $clog2(MW + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]        CNT_LAST = CW'(MW);
    localparam logic signed [EW+1:0] BIAS_S   = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] EMAX_S   = (EW+2)'((1 << EW) - 1);
    localparam logic signed [EW+1:0] EMIN_S   = (EW+2)'(1);

    // Control and datapath state
    logic [1:0]           state_q, state_d;
    logic                 sign_q, sign_d;
    logic                 zop_q, zop_d;
    logic signed [EW+1:0] esum_q, esum_d;
    logic [PW-1:0]        mcand_q, mcand_d;
    logic [MW:0]          mplier_q, mplier_d;
    logic [PW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         z_q, z_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 zero_q, zero_d;
    logic                 out_valid_q, out_valid_d;

    // Normalisation / rounding intermediates
    logic                 norm_inc_s;
    logic [MW-1:0]        mant_s;
    logic                 guard_s;
    logic                 sticky_s;
    logic                 round_up_s;
    logic [MW:0]          mant_rnd_s;
    logic signed [EW+1:0] e_s;
    logic [W-1:0]         res_z_s;
    logic                 res_ovf_s;
    logic                 res_unf_s;
    logic                 res_zero_s;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign bus.zero      = zero_q;

    // Normalise the finished product, round to nearest-even, and classify the result.
    always_comb begin
        norm_inc_s = acc_q[PW-1];
        if (norm_inc_s) begin
            mant_s   = acc_q[2*MW:MW+1];
            guard_s  = acc_q[MW];
            sticky_s = |acc_q[MW-1:0];
        end else begin
            mant_s   = acc_q[2*MW-1:MW];
            guard_s  = acc_q[MW-1];
            sticky_s = |acc_q[MW-2:0];
        end
        round_up_s = guard_s & (sticky_s | mant_s[0]);
        mant_rnd_s = {1'b0, mant_s} + {{MW{1'b0}}, round_up_s};
        // A rounding carry leaves the mantissa bits at zero and bumps the exponent.
        e_s = esum_q + $signed({{(EW+1){1'b0}}, norm_inc_s})
                     + $signed({{(EW+1){1'b0}}, mant_rnd_s[MW]});

        res_ovf_s  = 1'b0;
        res_unf_s  = 1'b0;
        res_zero_s = 1'b0;
        if (zop_q) begin
            res_z_s    = {sign_q, {(W-1){1'b0}}};
            res_zero_s = 1'b1;
        end else if (e_s > EMAX_S) begin
            res_z_s   = {sign_q, {(W-1){1'b1}}};
            res_ovf_s = 1'b1;
        end else if (e_s < EMIN_S) begin
            res_z_s   = {sign_q, {(W-1){1'b0}}};
            res_unf_s = 1'b1;
        end else begin
            res_z_s = {sign_q, e_s[EW-1:0], mant_rnd_s[MW-1:0]};
        end
    end

    // Next-state logic for the IDLE -> MUL -> NORM -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        zop_d       = zop_q;
        esum_d      = esum_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        z_d         = z_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sign_d   = bus.x[W-1] ^ bus.y[W-1];
                    zop_d    = (bus.x[W-2:MW] == {EW{1'b0}}) | (bus.y[W-2:MW] == {EW{1'b0}});
                    esum_d   = $signed({2'b00, bus.x[W-2:MW]}) + $signed({2'b00, bus.y[W-2:MW]}) - BIAS_S;
                    mcand_d  = {{(PW-MW-1){1'b0}}, 1'b1, bus.x[MW-1:0]};
                    mplier_d = {1'b1, bus.y[MW-1:0]};
                    acc_d    = {PW{1'b0}};
                    cnt_d    = {CW{1'b0}};
                    state_d  = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                // Multiplier bits are consumed LSB first against a left-shifting multiplicand.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d = S_NORM;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_NORM: begin
                z_d         = res_z_s;
                ovf_d       = res_ovf_s;
                unf_d       = res_unf_s;
                zero_d      = res_zero_s;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            zop_q       <= 1'b0;
            esum_q      <= {(EW+2){1'b0}};
            mcand_q     <= {PW{1'b0}};
            mplier_q    <= {(MW+1){1'b0}};
            acc_q       <= {PW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            z_q         <= {W{1'b0}};
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            zop_q       <= zop_d;
            esum_q      <= esum_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            z_q         <= z_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq.
// Default instance: EW=4, MW=7.
// Wide instance: EW=5, MW=10.
// Expected values come from an integer-arithmetic reference model.
module tb_fp_mult_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fp_mult_seq_if #(.W(12)) ifa ();
    fp_mult_seq_if #(.W(16)) ifb ();

    fp_mult_seq #(.EW(4), .MW(7),  .BIAS(7))  u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    fp_mult_seq #(.EW(5), .MW(10), .BIAS(15)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer product, then round-to-nearest-even on the shifted-out part.
    task automatic ref_mul(input int ew, input int mw, input int bias,
                           input longint a, input longint b,
                           output longint zr, output logic [2:0] fl);
        longint sa, sb, ea, eb, ma, mb, s, p, q, r, half, e, sh;
        sa = (a >> (ew + mw)) & 1;
        sb = (b >> (ew + mw)) & 1;
        ea = (a >> mw) & ((64'sd1 << ew) - 1);
        eb = (b >> mw) & ((64'sd1 << ew) - 1);
        ma = a & ((64'sd1 << mw) - 1);
        mb = b & ((64'sd1 << mw) - 1);
        s  = sa ^ sb;
        fl = 3'b000;
        if (ea == 0 || eb == 0) begin
            zr = s << (ew + mw);
            fl = 3'b001;
        end else begin
            p  = ((64'sd1 << mw) + ma) * ((64'sd1 << mw) + mb);
            sh = (p >= (64'sd1 << (2 * mw + 1))) ? mw + 1 : mw;
            e  = ea + eb - bias + (sh - mw);
            q  = p >> sh;
            r  = p - (q << sh);
            half = 64'sd1 << (sh - 1);
            if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
            if (q == (64'sd2 << mw)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e > (64'sd1 << ew) - 1) begin
                zr = (s << (ew + mw)) | ((64'sd1 << (ew + mw)) - 1);
                fl = 3'b100;
            end else if (e < 1) begin
                zr = s << (ew + mw);
                fl = 3'b010;
            end else begin
                zr = (s << (ew + mw)) | (e << mw) | (q - (64'sd1 << mw));
            end
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? ifb.in_ready : ifa.in_ready;
    endfunction
    function automatic logic ovl(input bit sel);
        return sel ? ifb.out_valid : ifa.out_valid;
    endfunction
    function automatic logic [15:0] zout(input bit sel);
        return sel ? ifb.z : {4'h0, ifa.z};
    endfunction
    function automatic logic [2:0] flg(input bit sel);
        return sel ? {ifb.ovf, ifb.unf, ifb.zero} : {ifa.ovf, ifa.unf, ifa.zero};
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [15:0] xa, input logic [15:0] ya);
        if (sel) begin
            ifb.in_valid = v; ifb.x = xa; ifb.y = ya;
        end else begin
            ifa.in_valid = v; ifa.x = xa[11:0]; ifa.y = ya[11:0];
        end
    endtask

    // One transaction. Latency counts clock edges from accept to out_valid, bounded at 40.
    task automatic op(input bit sel, input logic [15:0] xa, input logic [15:0] ya,
                      output logic [15:0] zr, output logic [2:0] fl, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {31'd0, rdy(sel)}, 32'd1);
        drive(sel, 1'b1, xa, ya);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, xa, ya);
        lat = 0;
        while (!ovl(sel) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        zr = zout(sel);
        fl = flg(sel);
        if ((sel ? ifb.out_ready : ifa.out_ready) == 1'b1) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [11:0] vx [8] = '{12'h3C0, 12'h400, 12'hBC0, 12'h3C1, 12'h381, 12'h7FF, 12'h081, 12'h000};
    logic [11:0] vy [8] = '{12'h3C0, 12'h400, 12'h3C0, 12'h3C0, 12'h381, 12'h7FF, 12'h081, 12'hBC0};
    logic [11:0] vz [8] = '{12'h410, 12'h480, 12'hC10, 12'h411, 12'h382, 12'h7FF, 12'h000, 12'h800};
    logic [2:0]  vf [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001};

    initial begin
        logic [15:0] zr;
        logic [2:0]  fl;
        int          lat;
        longint      mz;
        logic [2:0]  mf;
        logic [15:0] ra, rb;
        logic        seen;

        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0, 16'h0);
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        chk("rst_in_ready", {31'd0, ifa.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
        chk("rst_z", {20'd0, ifa.z}, 32'd0);
        chk("rst_flags", {29'd0, ifa.ovf, ifa.unf, ifa.zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: basic products, rounding and special cases.
        for (int i = 0; i < 8; i++) begin
            op(1'b0, {4'h0, vx[i]}, {4'h0, vy[i]}, zr, fl, lat);
            chk($sformatf("dir%0d_z", i), {16'd0, zr}, {20'd0, vz[i]});
            chk($sformatf("dir%0d_flags", i), {29'd0, fl}, {29'd0, vf[i]});
            chk($sformatf("dir%0d_latency", i), lat, 32'd9);
        end

        // Backpressure: the result must hold while competing operands are offered.
        @(negedge clk);
        ifa.out_ready = 1'b0;
        op(1'b0, 16'h3C1, 16'h3C0, zr, fl, lat);
        chk("bp_z", {16'd0, zr}, 32'h411);
        chk("bp_latency", lat, 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 16'h7FF, 16'h7FF);
            @(posedge clk);
            #1;
            chk("bp_hold_valid", {31'd0, ifa.out_valid}, 32'd1);
            chk("bp_hold_z", {20'd0, ifa.z}, 32'h411);
            chk("bp_hold_flags", {29'd0, ifa.ovf, ifa.unf, ifa.zero}, 32'd0);
            chk("bp_hold_in_ready", {31'd0, ifa.in_ready}, 32'd0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        ifa.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", {31'd0, ifa.in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, ifa.out_valid}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | ifa.out_valid;
        end
        chk("bp_offered_not_consumed", {31'd0, seen}, 32'd0);

        // Reset three cycles into MUL. The z register still holds 0x411 at this point.
        @(negedge clk);
        drive(1'b0, 1'b1, 16'h3C1, 16'h3C1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_z", {20'd0, ifa.z}, 32'd0);
        chk("midrst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, ifa.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            seen = seen | ifa.out_valid;
        end
        chk("midrst_no_stale_result", {31'd0, seen}, 32'd0);
        op(1'b0, 16'h3C0, 16'h3C0, zr, fl, lat);
        chk("midrst_next_z", {16'd0, zr}, 32'h410);
        chk("midrst_next_latency", lat, 32'd9);

        // Random operands over the full default range; specials included.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom_range(0, 4095));
            rb = 16'($urandom_range(0, 4095));
            ref_mul(4, 7, 7, longint'(ra), longint'(rb), mz, mf);
            op(1'b0, ra, rb, zr, fl, lat);
            chk($sformatf("rndA_z %h*%h", ra, rb), {16'd0, zr}, 32'(mz));
            chk($sformatf("rndA_flags %h*%h", ra, rb), {29'd0, fl}, {29'd0, mf});
        end

        // Wide instance: non-special operands, with a 12-cycle latency.
        for (int i = 0; i < 24; i++) begin
            ra = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom_range(0, 1023))};
            rb = {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom_range(0, 1023))};
            ref_mul(5, 10, 15, longint'(ra), longint'(rb), mz, mf);
            op(1'b1, ra, rb, zr, fl, lat);
            chk($sformatf("rndB_z %h*%h", ra, rb), {16'd0, zr}, 32'(mz));
            chk($sformatf("rndB_flags %h*%h", ra, rb), {29'd0, fl}, {29'd0, mf});
            chk("rndB_latency", lat, 32'd12);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mult_seq.md
Name: fp_mult_seq

Overview:
- Parametrised, sequential successor to the team's combinational 12-bit float multiplier.
- Operands use the sign/exponent/mantissa format with a hidden leading one; exponent and mantissa widths are parameters.
- The mantissa product is formed by an iterative radix-2 shift-add datapath. Rounding is round-to-nearest-even (the predecessor truncated).
- Adds zero detection, overflow saturation and underflow flush-to-zero, plus valid/ready handshakes, so it can sit between the register file and the writeback stage.

Parameters:
EW, 4, exponent field width (bits)
MW, 7, stored mantissa width (hidden bit not stored)
BIAS, 7, exponent bias; must equal 2^(EW-1)-1
W, 1+EW+MW, derived operand/result width; not overridable

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
in_valid  in  1  operands x,y valid
in_ready  out  1  block can accept operands
x  in  W  operand A {sign, exp[EW-1:0], mant[MW-1:0]}
y  in  W  operand B, same format
out_valid  out  1  result z and flags valid
out_ready  in  1  consumer accepts result
z  out  W  product
ovf  out  1  result saturated (overflow)
unf  out  1  result flushed to zero (underflow)
zero  out  1  result is zero because an operand is zero

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately, also mid-operation:
  - state=IDLE.
  - out_valid, z, ovf, unf, zero all 0; in_ready=1.
  - Any in-flight operation is discarded; no output is produced for it after release.
- FSM states: IDLE -> MUL -> NORM -> DONE -> IDLE.
  - IDLE: in_ready=1. When in_valid is high, latch x and y, sign = xs^ys, and the exponent sum; go to MUL.
  - MUL: exactly MW+1 cycles. Each cycle conditionally adds the shifted multiplicand {1,xm} per bit of {1,ym}, LSB first. The iteration counter is ceil(log2(MW+2)) bits. After the last iteration, go to NORM.
  - NORM: one cycle. Normalise, round, apply exponent and special-case rules, then register z, flags and out_valid=1. Go to DONE.
  - DONE: hold z and flags stable while out_valid=1. When out_ready is high, clear out_valid and go to IDLE.
- in_ready is 1 only in IDLE. Operands offered in other states are not accepted. No pipelining; one operation in flight.
- Latency: accept edge T, then out_valid=1 after edge T+MW+2 (9 cycles at default). Throughput is one result per MW+4 cycles when out_ready is held high.
- Product P is 2MW+2 bits.
  - If P[2MW+1]=1: mant=P[2MW:MW+1], guard=P[MW], sticky=|P[MW-1:0]; norm_inc=1.
  - Else: mant=P[2MW-1:MW], guard=P[MW-1], sticky=|P[MW-2:0]; norm_inc=0.
  - RNE: increment mant if guard & (sticky | mant[0]). If the increment carries out, mant=0 and the exponent is incremented again.
- Exponent: e = xe + ye - BIAS + norm_inc + round_carry, computed signed in EW+2 bits.
- Special cases, in priority order:
  1. Either operand has exp field 0: z={sign,0...}, zero=1. Exp-0 operands are treated as zero; no denormals.
  2. e > 2^EW-1: z={sign, all-ones exp, all-ones mant}, ovf=1.
  3. e < 1: z={sign,0...}, unf=1.
  4. Otherwise: z={sign, e[EW-1:0], mant}, all flags 0.
- The all-ones exponent is an ordinary finite value; there is no inf/NaN.
- Flags are mutually exclusive and are valid only while out_valid=1.

Test Plan:
- Basic products, all with zero flags clear:
  - x=0x3C0 (1.5), y=0x3C0 -> z=0x410 (2.25).
  - x=0x400, y=0x400 -> z=0x480.
  - x=0xBC0, y=0x3C0 -> z=0xC10.
  - out_valid rises exactly 9 cycles after accept.
- Rounding: x=0x3C1, y=0x3C0 -> z=0x411 (guard=1, sticky=1, round up; truncation would give 0x410). x=0x381, y=0x381 -> z=0x382 (no round).
- Special cases:
  - x=0x7FF, y=0x7FF -> z=0x7FF, ovf=1.
  - x=0x081, y=0x081 -> z=0x000, unf=1.
  - x=0x000, y=0xBC0 -> z=0x800, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - z, flags and out_valid stay stable; in_ready stays 0.
  - New x/y offered meanwhile are not consumed.
  - Release out_ready -> in_ready=1 on the next cycle.
- Reset mid-MUL: drop rst_n 3 cycles after accept.
  - Outputs clear immediately.
  - After release: in_ready=1; no out_valid for the aborted operation.
  - The next operation (0x3C0 x 0x3C0) returns 0x410.
- Parameter sweep: EW=5, MW=10, BIAS=15. Compare randomised non-special operands against a reference model with RNE; latency must be MW+2=12 cycles.
